// File: rtl/ct_f_spsram_access_ctrl_pkg.sv
// Shared encodings for the single-port SRAM access controller:
// FSM states and the active-low SRAM control levels.
package ct_f_spsram_access_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam logic CEN_ON  = 1'b0;
  localparam logic GWEN_WR = 1'b0;

endpackage

// File: rtl/ct_f_spsram_rsp_hold.sv
// Read-response register: presents live SRAM Q the cycle after a read and
// captures it into a holding register while the consumer back-pressures.
module ct_f_spsram_rsp_hold #(
  parameter int DATA_WIDTH = 84
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rd_fire_i,
  input  logic                  rsp_rdy_i,
  input  logic [DATA_WIDTH-1:0] sram_q_i,
  output logic                  rsp_vld_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o
);

  logic                  rsp_vld_q;
  logic                  rsp_from_q_q;
  logic [DATA_WIDTH-1:0] hold_q;

  // Q is only guaranteed for one cycle, so a stalled response is parked in hold_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_q    <= 1'b0;
      rsp_from_q_q <= 1'b0;
      hold_q       <= '0;
    end else if (rd_fire_i) begin
      rsp_vld_q    <= 1'b1;
      rsp_from_q_q <= 1'b1;
    end else if (rsp_vld_q && rsp_rdy_i) begin
      rsp_vld_q    <= 1'b0;
    end else if (rsp_vld_q && rsp_from_q_q) begin
      hold_q       <= sram_q_i;
      rsp_from_q_q <= 1'b0;
    end
  end

  assign rsp_vld_o   = rsp_vld_q;
  assign rsp_rdata_o = rsp_from_q_q ? sram_q_i : hold_q;

endmodule

// File: rtl/ct_f_spsram_access_ctrl.sv
// Initiator-side controller for a single-port SRAM macro: zero-fills the
// array after reset, then serves valid/ready read and masked-write requests.
module ct_f_spsram_access_ctrl
  import ct_f_spsram_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 84,
  parameter int INIT_EN    = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam state_e RST_ST = (INIT_EN != 0) ? ST_INIT : ST_IDLE;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  fire;
  logic                  rd_fire;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= RST_ST;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    req_rdy    = 1'b0;
    fire       = 1'b0;
    sram_cen   = ~CEN_ON;
    sram_gwen  = ~GWEN_WR;
    sram_wen   = '1;
    sram_a     = req_addr;
    sram_d     = req_wdata;
    case (state_q)
      ST_INIT: begin
        sram_a   = init_cnt_q;
        sram_d   = '0;
        sram_wen = '0;
        // Gated by reset so the macro is released the instant reset asserts.
        if (cpurst_b) begin
          sram_cen  = CEN_ON;
          sram_gwen = GWEN_WR;
        end
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        req_rdy   = !rsp_vld || rsp_rdy;
        fire      = req_vld && req_rdy;
        sram_cen  = !fire;
        sram_gwen = !(fire && req_wr);
        sram_wen  = (fire && req_wr) ? ~req_wmask : '1;
      end
      default: ;
    endcase
  end

  assign init_done = (state_q == ST_IDLE);
  assign rd_fire   = fire && !req_wr;

  ct_f_spsram_rsp_hold #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_hold (
    .clk_i       (forever_cpuclk),
    .rst_ni      (cpurst_b),
    .rd_fire_i   (rd_fire),
    .rsp_rdy_i   (rsp_rdy),
    .sram_q_i    (sram_q),
    .rsp_vld_o   (rsp_vld),
    .rsp_rdata_o (rsp_rdata)
  );

endmodule

// File: tb/tb_ct_f_spsram_access_ctrl.sv
// Directed bench for ct_f_spsram_access_ctrl with a small behavioural SRAM.
module tb_ct_f_spsram_access_ctrl;

  localparam int AW = 4;
  localparam int DW = 84;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          req_vld = 1'b0, req_rdy, req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, req_wmask = '0;
  logic          rsp_vld, rsp_rdy = 1'b1, init_done;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sram_a;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  ct_f_spsram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_rdata      (rsp_rdata),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // SRAM model: Q is meaningful only after a read; otherwise it is scrambled.
  logic [DW-1:0] mem [1<<AW];
  int            cyc = 0;
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = {3{28'hC3C3C3C}} ^ DW'(i);
    sram_q = '0;
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!sram_cen && sram_gwen) sram_q <= mem[sram_a];
    else sram_q <= {3{28'hBAD0000}} ^ DW'(cyc);
    if (!sram_cen && !sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic          vld;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
    logic          rrdy;
    logic          e_vld;
    logic [DW-1:0] e_data;
    logic          e_rdy;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic v, logic w, logic [AW-1:0] a, logic [DW-1:0] d,
                              logic [DW-1:0] m, logic rr, logic ev, logic [DW-1:0] ed, logic er);
    vec_t t;
    t.vld = v; t.wr = w; t.addr = a; t.wdata = d; t.wmask = m; t.rrdy = rr;
    t.e_vld = ev; t.e_data = ed; t.e_rdy = er;
    return t;
  endfunction

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] m, input logic rr);
    req_vld = v; req_wr = w; req_addr = a; req_wdata = d; req_wmask = m; rsp_rdy = rr;
  endtask

  task automatic fill_check();
    for (int i = 0; i < (1 << AW); i++) begin
      #1;
      chk($sformatf("fill_a%0d", i), DW'(sram_a), DW'(i));
      chk($sformatf("fill_ctl%0d", i), DW'({sram_cen, sram_gwen, req_rdy, init_done}), '0);
      if (i == 0 || i == (1 << AW) - 1) begin
        chk($sformatf("fill_d%0d", i), sram_d, '0);
        chk($sformatf("fill_wen%0d", i), sram_wen, '0);
      end
      @(negedge clk);
    end
    #1;
    chk("init_done_rise", DW'(init_done), DW'(1));
    chk("idle_cen", DW'(sram_cen), DW'(1));
    chk("idle_req_rdy", DW'(req_rdy), DW'(1));
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 3, 84'h5A5, ONES,    1, 0, '0,      1);
    tbl[1]  = mk(1, 0, 3, '0,      '0,      1, 0, '0,      1);
    tbl[2]  = mk(0, 0, 0, '0,      '0,      1, 1, 84'h5A5, 1);
    tbl[3]  = mk(1, 1, 3, '0,      84'h00F, 1, 0, '0,      1);
    tbl[4]  = mk(1, 0, 3, '0,      '0,      1, 0, '0,      1);
    tbl[5]  = mk(0, 0, 0, '0,      '0,      1, 1, 84'h5A0, 1);
    tbl[6]  = mk(1, 0, 1, '0,      '0,      1, 0, '0,      1);
    tbl[7]  = mk(1, 0, 2, '0,      '0,      1, 1, '0,      1);
    tbl[8]  = mk(1, 0, 3, '0,      '0,      1, 1, '0,      1);
    tbl[9]  = mk(0, 0, 0, '0,      '0,      1, 1, 84'h5A0, 1);
    tbl[10] = mk(0, 0, 0, '0,      '0,      1, 0, '0,      1);
    tbl[11] = mk(1, 0, 3, '0,      '0,      1, 0, '0,      1);
    tbl[12] = mk(1, 1, 5, 84'h777, ONES,    1, 1, 84'h5A0, 1);
    tbl[13] = mk(1, 0, 5, '0,      '0,      1, 0, '0,      1);
    tbl[14] = mk(0, 0, 0, '0,      '0,      1, 1, 84'h777, 1);
    tbl[15] = mk(1, 1, 5, ONES,    '0,      1, 0, '0,      1);
    tbl[16] = mk(1, 0, 5, '0,      '0,      1, 0, '0,      1);
    tbl[17] = mk(0, 0, 0, '0,      '0,      1, 1, 84'h777, 1);

    // Reset state
    #1;
    chk("rst_vld", DW'(rsp_vld), '0);
    chk("rst_init_done", DW'(init_done), '0);
    chk("rst_req_rdy", DW'(req_rdy), '0);
    chk("rst_cen", DW'(sram_cen), DW'(1));
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    fill_check();

    // Table vectors: drive, then check outputs within the same cycle
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].vld, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, tbl[i].rrdy);
      #1;
      chk($sformatf("v%0d_vld", i), DW'(rsp_vld), DW'(tbl[i].e_vld));
      chk($sformatf("v%0d_rdy", i), DW'(req_rdy), DW'(tbl[i].e_rdy));
      if (tbl[i].e_vld) chk($sformatf("v%0d_data", i), rsp_rdata, tbl[i].e_data);
      @(negedge clk);
    end

    // Back-pressure: stalled read response must hold data while Q is scrambled
    drive(1, 0, 3, '0, '0, 0);
    #1 chk("bp_fire_rdy", DW'(req_rdy), DW'(1));
    @(negedge clk);
    drive(0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d_vld", i), DW'(rsp_vld), DW'(1));
      chk($sformatf("bp%0d_data", i), rsp_rdata, 84'h5A0);
      chk($sformatf("bp%0d_rdy", i), DW'(req_rdy), '0);
      @(negedge clk);
    end
    rsp_rdy = 1'b1;
    #1;
    chk("bp_acc_vld", DW'(rsp_vld), DW'(1));
    chk("bp_acc_data", rsp_rdata, 84'h5A0);
    chk("bp_acc_rdy", DW'(req_rdy), DW'(1));
    @(negedge clk);
    #1 chk("bp_done_vld", DW'(rsp_vld), '0);

    // Pending stalled response is dropped by reset
    @(negedge clk);
    drive(1, 0, 3, '0, '0, 0);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, 0);
    #1 chk("pend_vld", DW'(rsp_vld), DW'(1));
    rst_b = 1'b0;
    #1 chk("pend_rst_vld", DW'(rsp_vld), '0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (7) @(negedge clk);
    #1;
    chk("mid_a7", DW'(sram_a), DW'(7));
    chk("mid_cen7", DW'(sram_cen), '0);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_cen", DW'(sram_cen), DW'(1));
    chk("mid_rst_vld", DW'(rsp_vld), '0);
    chk("mid_rst_done", DW'(init_done), '0);
    @(negedge clk);
    rst_b = 1'b1;
    fill_check();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
